// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_arb_pkg : shared encodings and sizing helper for imem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package imem_arb_pkg;

  localparam logic [0:0] S_FETCH_PRI = 1'b0;
  localparam logic [0:0] S_LOAD_PRI  = 1'b1;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_e;

  // Counter only has to hold 0..limit-1; keep at least one bit for limit = 1.
  function automatic int starve_cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rsp_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_rsp_pipe : two-stage valid/owner shift register steering read responses
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_rsp_pipe
  import imem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic owner_i,
  output logic fetch_rvalid_o,
  output logic load_rvalid_o
);

  logic   rsp_valid_q, rsp_valid_d;
  owner_e rsp_owner_q, rsp_owner_d;
  logic   dat_valid_q, dat_valid_d;
  owner_e dat_owner_q, dat_owner_d;

  always_comb begin
    rsp_valid_d = issue_i;
    rsp_owner_d = owner_e'(owner_i);
    dat_valid_d = rsp_valid_q;
    dat_owner_d = rsp_owner_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWN_FETCH;
      dat_valid_q <= 1'b0;
      dat_owner_q <= OWN_FETCH;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      dat_valid_q <= dat_valid_d;
      dat_owner_q <= dat_owner_d;
    end
  end

  // Masking with reset keeps a response from escaping in the reset cycle itself.
  assign fetch_rvalid_o = dat_valid_q && (dat_owner_q == OWN_FETCH) && !rst_i;
  assign load_rvalid_o  = dat_valid_q && (dat_owner_q == OWN_LOAD)  && !rst_i;

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_port_arbiter : fetch/loader arbiter for the single-port instruction memory
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_req_i,
  input  logic [ADDR_BITS-1:0]   fetch_addr_i,
  output logic                   fetch_gnt_o,
  output logic                   fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0]  fetch_rdata_o,
  input  logic                   load_req_i,
  input  logic                   load_we_i,
  input  logic                   load_lock_i,
  input  logic [ADDR_BITS-1:0]   load_addr_i,
  input  logic [DATA_WIDTH-1:0]  load_wdata_i,
  output logic                   load_gnt_o,
  output logic                   load_rvalid_o,
  output logic [DATA_WIDTH-1:0]  load_rdata_o,
  output logic                   mem_we_o,
  output logic [ADDR_BITS/2-1:0] mem_x_addr_o,
  output logic [ADDR_BITS/2-1:0] mem_y_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i
);

  localparam int                 c_half       = ADDR_BITS / 2;
  localparam int                 c_cnt_w      = starve_cnt_width(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT - 1);

  logic [0:0]            state_q, state_d;
  logic [c_cnt_w-1:0]    starve_q, starve_d;
  logic [c_cnt_w-1:0]    starve_inc;
  logic                  starve_hit;
  logic                  load_deny;
  logic                  fetch_gnt, load_gnt, any_gnt;
  logic [ADDR_BITS-1:0]  win_addr;
  logic [c_half-1:0]     x_addr_q, x_addr_d;
  logic [c_half-1:0]     y_addr_q, y_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  rd_issue;

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!rst_i) begin
      if (state_q == S_LOAD_PRI) begin
        load_gnt  = load_req_i;
        fetch_gnt = fetch_req_i && !load_req_i;
      end else begin
        fetch_gnt = fetch_req_i;
        load_gnt  = load_req_i && !fetch_req_i;
      end
    end
  end

  // Forcing triggers on the denial that brings the counter to its ceiling,
  // so the loader waits STARVE_LIMIT-1 denied cycles before it takes over.
  always_comb begin
    load_deny  = load_req_i && !load_gnt;
    starve_inc = (starve_q == c_starve_max) ? starve_q : starve_q + c_cnt_w'(1);
    starve_d   = load_deny ? starve_inc : '0;
    starve_hit = load_deny && (starve_inc == c_starve_max);

    state_d = state_q;
    case (state_q)
      S_FETCH_PRI: begin
        if (load_req_i && (load_lock_i || starve_hit)) begin
          state_d = S_LOAD_PRI;
        end
      end
      S_LOAD_PRI: begin
        if (!load_req_i || (load_gnt && !load_lock_i)) begin
          state_d = S_FETCH_PRI;
        end
      end
      default: state_d = S_FETCH_PRI;
    endcase
  end

  always_comb begin
    any_gnt  = fetch_gnt || load_gnt;
    win_addr = load_gnt ? load_addr_i : fetch_addr_i;
    x_addr_d = any_gnt ? win_addr[ADDR_BITS-1:c_half] : x_addr_q;
    y_addr_d = any_gnt ? win_addr[c_half-1:0]         : y_addr_q;
    wdata_d  = any_gnt ? load_wdata_i                 : wdata_q;
    we_d     = load_gnt && load_we_i;
    rd_issue = fetch_gnt || (load_gnt && !load_we_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH_PRI;
      starve_q <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  imem_rsp_pipe u_rsp_pipe (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_i        (rd_issue),
    .owner_i        (load_gnt),
    .fetch_rvalid_o (fetch_rvalid_o),
    .load_rvalid_o  (load_rvalid_o)
  );

  assign fetch_gnt_o   = fetch_gnt;
  assign load_gnt_o    = load_gnt;
  assign mem_we_o      = we_q && !rst_i;
  assign mem_x_addr_o  = x_addr_q;
  assign mem_y_addr_o  = y_addr_q;
  assign mem_wdata_o   = wdata_q;
  assign fetch_rdata_o = mem_rdata_i;
  assign load_rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter : randomized scoreboard bench for imem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

  localparam int AB  = 8;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [AB-1:0] fetch_addr;
  logic [DW-1:0] fetch_rdata;
  logic          load_req, load_we, load_lock, load_gnt, load_rvalid;
  logic [AB-1:0] load_addr;
  logic [DW-1:0] load_wdata, load_rdata;
  logic          mem_we;
  logic [AB/2-1:0] mem_x, mem_y;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .load_req_i(load_req), .load_we_i(load_we), .load_lock_i(load_lock),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_gnt_o(load_gnt),
    .load_rvalid_o(load_rvalid), .load_rdata_o(load_rdata),
    .mem_we_o(mem_we), .mem_x_addr_o(mem_x), .mem_y_addr_o(mem_y),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Stand-in for the imem: registered address in, read-first registered data out.
  logic [DW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_we) tb_mem[{mem_x, mem_y}] <= mem_wdata;
    mem_rdata <= tb_mem[{mem_x, mem_y}];
  end

  typedef struct {
    bit            own_load;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AB-1:0] rand_addr();
    logic [AB-1:0] a;
    if ($urandom_range(0, 3) == 0) a = AB'($urandom);
    else a = AB'($urandom_range(8'h30, 8'h37));
    return a;
  endfunction

  // Response monitor: pops the scoreboard whenever a read response appears.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rvalid_in_reset", {62'd0, fetch_rvalid, load_rvalid}, 64'd0);
        exp_q.delete();
      end else begin
        check("rvalid_exclusive", {63'd0, fetch_rvalid && load_rvalid}, 64'd0);
        if (fetch_rvalid || load_rvalid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rvalid", {62'd0, fetch_rvalid, load_rvalid}, 64'd0);
          end else begin
            r = exp_q.pop_front();
            check("rsp_cycle", 64'(cyc), 64'(r.due));
            check("rsp_owner_load", {63'd0, load_rvalid}, {63'd0, r.own_load});
            check("rsp_rdata", 64'(load_rvalid ? load_rdata : fetch_rdata), 64'(r.data));
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          r = exp_q.pop_front();
          check("rsp_missing", {62'd0, fetch_rvalid, load_rvalid},
                r.own_load ? 64'd1 : 64'd2);
        end
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  bit            load_first;
  int            deny_run;
  logic [AB/2-1:0] exp_x, exp_y;
  logic [DW-1:0] exp_wd;
  bit            exp_we;
  bit            pw_valid;
  logic [AB-1:0] pw_addr;
  logic [DW-1:0] pw_data;

  initial begin
    bit            f_hold, l_hold, eg_f, eg_l, both_mode, do_rst;
    int            burst_left;
    logic [AB-1:0] a;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA000_0000 | 32'(i) | ($urandom & 32'h0FFF_FF00);
      ref_mem[i] = tb_mem[i];
    end
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    load_req = 1'b0; load_we = 1'b0; load_lock = 1'b0; load_addr = '0; load_wdata = '0;
    load_first = 1'b0; deny_run = 0;
    exp_x = '0; exp_y = '0; exp_wd = '0; exp_we = 1'b0; pw_valid = 1'b0;
    f_hold = 1'b0; l_hold = 1'b0; burst_left = 0;
    repeat (2) @(posedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      both_mode = (c >= 2 && c < 14);
      do_rst = (c < 2) || (c > 20 && $urandom_range(0, 149) == 0);
      rst = do_rst;
      if (c >= 2990) begin
        if (!f_hold) fetch_req = 1'b0;
        if (!l_hold) load_req = 1'b0;
        load_lock = 1'b0;
        burst_left = 0;
      end else begin
        if (!f_hold) begin
          fetch_req  = both_mode ? 1'b1 : ($urandom_range(0, 9) < 6);
          fetch_addr = rand_addr();
        end
        if (!l_hold) begin
          load_req   = both_mode ? 1'b1 : (burst_left > 0 || $urandom_range(0, 9) < 4);
          load_we    = both_mode ? 1'b0 : 1'($urandom_range(0, 1));
          load_addr  = rand_addr();
          load_wdata = $urandom;
        end
        if (burst_left > 0) begin
          load_lock = 1'b1;
          burst_left--;
        end else begin
          load_lock = 1'b0;
          if (!both_mode && $urandom_range(0, 29) == 0) burst_left = $urandom_range(2, 9);
        end
      end

      @(negedge clk);
      if (rst) begin
        eg_f = 1'b0;
        eg_l = 1'b0;
      end else if (load_first) begin
        eg_l = load_req;
        eg_f = fetch_req && !load_req;
      end else begin
        eg_f = fetch_req;
        eg_l = load_req && !fetch_req;
      end
      check("fetch_gnt", {63'd0, fetch_gnt}, {63'd0, eg_f});
      check("load_gnt",  {63'd0, load_gnt},  {63'd0, eg_l});
      check("mem_x_addr", 64'(mem_x), 64'(exp_x));
      check("mem_y_addr", 64'(mem_y), 64'(exp_y));
      check("mem_wdata",  64'(mem_wdata), 64'(exp_wd));
      check("mem_we", {63'd0, mem_we}, {63'd0, exp_we && !rst});

      if (rst) begin
        load_first = 1'b0; deny_run = 0;
        exp_x = '0; exp_y = '0; exp_wd = '0; exp_we = 1'b0; pw_valid = 1'b0;
      end else begin
        // A granted write lands in the array only if the next cycle is not reset.
        if (pw_valid) ref_mem[pw_addr] = pw_data;
        pw_valid = eg_l && load_we;
        pw_addr  = load_addr;
        pw_data  = load_wdata;
        if (eg_f || eg_l) begin
          a      = eg_l ? load_addr : fetch_addr;
          exp_x  = a[AB-1:AB/2];
          exp_y  = a[AB/2-1:0];
          exp_wd = load_wdata;
        end
        exp_we = eg_l && load_we;
        if (eg_f) exp_q.push_back('{own_load: 1'b0, data: ref_mem[fetch_addr], due: cyc + 2});
        if (eg_l && !load_we)
          exp_q.push_back('{own_load: 1'b1, data: ref_mem[load_addr], due: cyc + 2});
        if (!load_first) begin
          if (load_req && (load_lock || (!eg_l && deny_run + 1 >= LIM - 1))) load_first = 1'b1;
        end else if (!load_req || (eg_l && !load_lock)) begin
          load_first = 1'b0;
        end
        deny_run = (load_req && !eg_l) ? deny_run + 1 : 0;
      end
      f_hold = fetch_req && !eg_f;
      l_hold = load_req && !eg_l;
    end

    @(posedge clk); #1;
    fetch_req = 1'b0; load_req = 1'b0; load_lock = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
